// File: rtl/huffman_pkg.sv
// Shared types and default SRAM address map for the Huffman heap builder.
package huffman_pkg;

  typedef struct packed {
    logic [7:0] freq;
    logic [7:0] sym;
  } node_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BUILD,
    STORE,
    DONE
  } state_t;

  localparam logic [15:0] FREQ_BASE_DEF = 16'h0000;
  localparam logic [15:0] HEAP_BASE_DEF = 16'h0100;
  localparam logic [15:0] CNT_ADDR_DEF  = 16'h0120;

endpackage

// File: rtl/huffman_node_cmp.sv
// Picks the smaller-keyed child of a heap node and flags whether it must swap with the parent.
module huffman_node_cmp
  import huffman_pkg::*;
#(
  parameter int unsigned XW = 6
) (
  input  node_t          parent,
  input  node_t          left,
  input  node_t          right,
  input  logic           l_valid,
  input  logic           r_valid,
  input  logic [XW-1:0]  l_idx,
  input  logic [XW-1:0]  r_idx,
  output logic [XW-1:0]  min_idx,
  output logic           swap
);

  logic [15:0] key_p;
  logic [15:0] key_l;
  logic [15:0] key_r;
  logic [15:0] key_min;

  assign key_p = parent;
  assign key_l = left;
  assign key_r = right;

  // Symbols are distinct, so keys never tie and strict compares suffice.
  always_comb begin
    min_idx = l_idx;
    key_min = key_l;
    if (r_valid && (key_r < key_l)) begin
      min_idx = r_idx;
      key_min = key_r;
    end
    swap = l_valid && (key_min < key_p);
  end

endmodule

// File: rtl/huffman_heap_builder.sv
// Loads a byte histogram from SRAM, Floyd-heapifies the nonzero symbols and writes the heap back.
module huffman_heap_builder
  import huffman_pkg::*;
#(
  parameter int unsigned NUM_SYM   = 16,
  parameter logic [15:0] FREQ_BASE = FREQ_BASE_DEF,
  parameter logic [15:0] HEAP_BASE = HEAP_BASE_DEF,
  parameter logic [15:0] CNT_ADDR  = CNT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        huff_start,
  input  logic [7:0]  data_read,
  output logic        huff_done,
  output logic        read,
  output logic        write,
  output logic [15:0] addr,
  output logic [7:0]  data
);

  localparam int unsigned IW = $clog2(NUM_SYM);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned XW = IW + 2;
  localparam int unsigned WW = CW + 1;

  state_t         state_q, state_d;
  logic           huff_done_q, huff_done_d;
  logic           read_q, read_d;
  logic           write_q, write_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  node_t          nodes_q [NUM_SYM];
  node_t          nodes_d [NUM_SYM];
  logic [CW-1:0]  count_q, count_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           phase_q, phase_d;
  logic [IW-1:0]  p_q, p_d;
  logic [IW-1:0]  cur_q, cur_d;
  logic [WW-1:0]  wr_q, wr_d;
  logic [CW-1:0]  half_cnt;

  logic [XW-1:0]  l_idx;
  logic [XW-1:0]  r_idx;
  logic [XW-1:0]  min_idx;
  logic           l_valid;
  logic           r_valid;
  logic           swap;

  assign l_idx   = XW'({cur_q, 1'b1});
  assign r_idx   = l_idx + XW'(1);
  assign l_valid = l_idx < XW'(count_q);
  assign r_valid = r_idx < XW'(count_q);

  huffman_node_cmp #(.XW(XW)) u_cmp (
    .parent  (nodes_q[cur_q]),
    .left    (nodes_q[IW'(l_idx)]),
    .right   (nodes_q[IW'(r_idx)]),
    .l_valid (l_valid),
    .r_valid (r_valid),
    .l_idx   (l_idx),
    .r_idx   (r_idx),
    .min_idx (min_idx),
    .swap    (swap)
  );

  always_comb begin
    state_d     = state_q;
    huff_done_d = 1'b0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    nodes_d     = nodes_q;
    count_d     = count_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    p_d         = p_q;
    cur_d       = cur_q;
    wr_d        = wr_q;
    half_cnt    = '0;

    case (state_q)
      IDLE: begin
        if (huff_start) begin
          state_d = LOAD;
          read_d  = 1'b1;
          addr_d  = FREQ_BASE;
          idx_d   = '0;
          count_d = '0;
          phase_d = 1'b0;
        end
      end

      LOAD: begin
        read_d = 1'b1;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (data_read != '0) begin
            nodes_d[count_q[IW-1:0]] = '{freq: data_read, sym: 8'(idx_q)};
            count_d = count_q + CW'(1);
          end
          if (idx_q == IW'(NUM_SYM - 1)) begin
            read_d   = 1'b0;
            state_d  = BUILD;
            half_cnt = count_d >> 1;
            p_d      = IW'(half_cnt) - IW'(1);
            cur_d    = IW'(half_cnt) - IW'(1);
          end else begin
            idx_d  = idx_q + IW'(1);
            addr_d = FREQ_BASE + 16'(idx_q) + 16'd1;
          end
        end
      end

      BUILD: begin
        // A no-swap step ends the current sift; the outer parent index then moves down by one.
        if (count_q < CW'(2)) begin
          state_d = STORE;
          write_d = 1'b1;
          wr_d    = '0;
        end else if (swap) begin
          nodes_d[cur_q]        = nodes_q[IW'(min_idx)];
          nodes_d[IW'(min_idx)] = nodes_q[cur_q];
          cur_d                 = IW'(min_idx);
        end else if (p_q == '0) begin
          state_d = STORE;
          write_d = 1'b1;
          wr_d    = '0;
        end else begin
          p_d   = p_q - IW'(1);
          cur_d = p_q - IW'(1);
        end
      end

      STORE: begin
        if (wr_q == {count_q, 1'b0}) begin
          state_d     = DONE;
          huff_done_d = 1'b1;
        end else begin
          write_d = 1'b1;
          wr_d    = wr_q + WW'(1);
        end
      end

      DONE: begin
        huff_done_d = 1'b1;
        if (!huff_start) begin
          state_d     = IDLE;
          huff_done_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Byte wr_d of the image: node bytes first, then the count byte at the end.
    if (write_d) begin
      if (wr_d == {count_d, 1'b0}) begin
        addr_d = CNT_ADDR;
        data_d = 8'(count_d);
      end else begin
        addr_d = HEAP_BASE + 16'(wr_d);
        data_d = wr_d[0] ? nodes_d[wr_d[IW:1]].sym : nodes_d[wr_d[IW:1]].freq;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      huff_done_q <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      for (int unsigned i = 0; i < NUM_SYM; i++) nodes_q[i] <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      p_q         <= '0;
      cur_q       <= '0;
      wr_q        <= '0;
    end else begin
      state_q     <= state_d;
      huff_done_q <= huff_done_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      nodes_q     <= nodes_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      p_q         <= p_d;
      cur_q       <= cur_d;
      wr_q        <= wr_d;
    end
  end

  assign huff_done = huff_done_q;
  assign read      = read_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign data      = data_q;

endmodule

// File: tb/tb_huffman_heap_builder.sv
// Bench for huffman_heap_builder: SRAM model, write/read logging and a Floyd-heapify reference.
module tb_huffman_heap_builder;

  localparam int          NSYM = 16;
  localparam logic [15:0] HEAP = 16'h0100;
  localparam logic [15:0] CNTA = 16'h0120;

  logic        clk = 1'b0;
  logic        rst;
  logic        huff_start;
  logic [7:0]  data_read = 8'h00;
  logic        huff_done;
  logic        read;
  logic        write;
  logic [15:0] addr;
  logic [7:0]  data;

  logic [7:0]  hist [NSYM];
  logic [23:0] wlog [$];
  logic [15:0] rlog [$];
  logic [23:0] exp_w [$];
  int          exp_cnt;
  int          wbase, rbase;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rw_clash = 0;

  always #5 clk = ~clk;

  huffman_heap_builder #(
    .NUM_SYM   (16),
    .FREQ_BASE (16'h0000),
    .HEAP_BASE (16'h0100),
    .CNT_ADDR  (16'h0120)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .huff_start (huff_start),
    .data_read  (data_read),
    .huff_done  (huff_done),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data       (data)
  );

  // SRAM: read data appears one cycle after the request, so it is valid in the 2nd read cycle.
  always @(posedge clk) begin
    data_read <= (addr < 16'd16) ? hist[addr[3:0]] : 8'h00;
    if (read && write) rw_clash++;
    if (write) wlog.push_back({addr, data});
    if (read) rlog.push_back(addr);
  end

  task automatic model();
    logic [15:0] key [NSYM];
    logic [15:0] t;
    int n, k, m, l, r;
    n = 0;
    for (int i = 0; i < NSYM; i++)
      if (hist[i] != 0) begin key[n] = {hist[i], 8'(i)}; n++; end
    for (int p = n / 2 - 1; p >= 0; p--) begin
      k = p;
      m = -1;
      while (m != k) begin
        m = k; l = 2 * k + 1; r = 2 * k + 2;
        if (l < n && key[l] < key[m]) m = l;
        if (r < n && key[r] < key[m]) m = r;
        if (m != k) begin t = key[k]; key[k] = key[m]; key[m] = t; k = m; m = -1; end
      end
    end
    exp_w.delete();
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({HEAP + 16'(2 * i), key[i][15:8]});
      exp_w.push_back({HEAP + 16'(2 * i + 1), key[i][7:0]});
    end
    exp_w.push_back({CNTA, 8'(n)});
    exp_cnt = n;
  endtask

  function automatic int first_diff();
    if (wlog.size() - wbase != exp_w.size()) return -2;
    foreach (exp_w[i]) if (wlog[wbase + i] !== exp_w[i]) return i;
    return -1;
  endfunction

  function automatic int bad_reads();
    int b = 0;
    if (rlog.size() - rbase != 2 * NSYM) return 99;
    for (int j = 0; j < 2 * NSYM; j++) if (rlog[rbase + j] !== 16'(j / 2)) b++;
    return b;
  endfunction

  function automatic int lat_bound(int n);
    int b;
    b = (n < 2) ? 1 : n * $clog2(n) + n / 2;
    return 34 + 2 * n + b;
  endfunction

  task automatic do_run(output int cycles);
    wbase = wlog.size();
    rbase = rlog.size();
    @(negedge clk);
    huff_start = 1'b1;
    cycles = 0;
    do begin @(negedge clk); cycles++; end while (!huff_done && cycles < 400);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    huff_start = 1'b0;
    foreach (hist[i]) hist[i] = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if (huff_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", huff_done); end
    n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL reset_read got %b exp 0", read); end
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL reset_write got %b exp 0", write); end
    n_cmp++; if (addr !== 16'h0) begin n_bad++; $display("FAIL reset_addr got %h exp 0000", addr); end
    n_cmp++; if (data !== 8'h0) begin n_bad++; $display("FAIL reset_data got %h exp 00", data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_descending();
    int cyc, d, viol;
    logic [15:0] kp, kc;
    for (int i = 0; i < NSYM; i++) hist[i] = 8'(16 - i);
    model();
    do_run(cyc);
    n_cmp++; if (huff_done !== 1'b1) begin n_bad++; $display("FAIL desc_done got %b exp 1 after %0d cycles", huff_done, cyc); end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL desc_image first bad entry %0d got %0d writes exp %0d", d, wlog.size() - wbase, exp_w.size()); end
    n_cmp++; if (wlog.size() > wbase + 1 && {wlog[wbase][7:0], wlog[wbase + 1][7:0]} !== 16'h010F) begin
      n_bad++; $display("FAIL desc_root got %h%h exp 010f", wlog[wbase][7:0], wlog[wbase + 1][7:0]); end
    n_cmp++; if (wlog.size() != wbase + 33 || wlog[wbase + 32] !== {CNTA, 8'd16}) begin
      n_bad++; $display("FAIL desc_count got %0d writes exp 33 ending %h", wlog.size() - wbase, {CNTA, 8'd16}); end
    viol = 0;
    if (wlog.size() >= wbase + 32)
      for (int k = 1; k < 16; k++) begin
        kp = {wlog[wbase + 2 * ((k - 1) / 2)][7:0], wlog[wbase + 2 * ((k - 1) / 2) + 1][7:0]};
        kc = {wlog[wbase + 2 * k][7:0], wlog[wbase + 2 * k + 1][7:0]};
        if (kp > kc) viol++;
      end
    else viol = 99;
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL desc_heap_order got %0d violations exp 0", viol); end
    n_cmp++; if (bad_reads() != 0) begin n_bad++; $display("FAIL desc_reads got %0d bad exp 0", bad_reads()); end
    n_cmp++; if (cyc > lat_bound(16)) begin n_bad++; $display("FAIL desc_latency got %0d exp <= %0d", cyc, lat_bound(16)); end
    huff_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    int cyc, d;
    foreach (hist[i]) hist[i] = 8'h00;
    model();
    do_run(cyc);
    n_cmp++; if (huff_done !== 1'b1 || cyc > 36) begin n_bad++; $display("FAIL zero_latency got done=%b at %0d cycles exp done by 36", huff_done, cyc); end
    d = first_diff();
    n_cmp++; if (d != -1 || exp_w.size() != 1) begin n_bad++; $display("FAIL zero_image got %0d writes (diff %0d) exp one write 0120=00", wlog.size() - wbase, d); end
    huff_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ties();
    int cyc, d;
    foreach (hist[i]) hist[i] = 8'h00;
    hist[3] = 8'd5; hist[7] = 8'd5; hist[9] = 8'd2;
    model();
    do_run(cyc);
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL ties_image first bad entry %0d got %0d writes exp %0d", d, wlog.size() - wbase, exp_w.size()); end
    // The root swaps only with node 2, so node 1 keeps {5,7} and node 2 takes {5,3}.
    n_cmp++; if (wlog.size() < wbase + 7 || wlog[wbase] !== {HEAP, 8'h02} || wlog[wbase + 1] !== {HEAP + 16'd1, 8'h09}
                 || wlog[wbase + 6] !== {CNTA, 8'h03}) begin
      n_bad++; $display("FAIL ties_root_count got %0d writes exp root 02/09 and count 03", wlog.size() - wbase); end
    huff_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc;
    foreach (hist[i]) hist[i] = 8'h00;
    hist[0] = 8'hFF;
    do_run(cyc);
    n_cmp++; if (wlog.size() != wbase + 3 || wlog[wbase] !== {HEAP, 8'hFF} || wlog[wbase + 1] !== {HEAP + 16'd1, 8'h00}
                 || wlog[wbase + 2] !== {CNTA, 8'h01}) begin
      n_bad++; $display("FAIL single_image got %0d writes exp 0100=ff 0101=00 0120=01", wlog.size() - wbase); end
    n_cmp++; if (cyc != 37) begin n_bad++; $display("FAIL single_latency got %0d exp 37", cyc); end
    huff_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_start();
    int cyc, d, rb, wb;
    for (int i = 0; i < NSYM; i++) hist[i] = (i % 3 == 0) ? 8'h00 : 8'($urandom_range(1, 4));
    model();
    do_run(cyc);
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL hold_first_image first bad entry %0d", d); end
    rb = rlog.size(); wb = wlog.size();
    repeat (20) @(negedge clk);
    n_cmp++; if (rlog.size() != rb || wlog.size() != wb) begin
      n_bad++; $display("FAIL hold_no_rerun got %0d reads %0d writes exp 0 0", rlog.size() - rb, wlog.size() - wb); end
    n_cmp++; if (huff_done !== 1'b1) begin n_bad++; $display("FAIL hold_done got %b exp 1", huff_done); end
    huff_start = 1'b0;
    @(negedge clk);
    n_cmp++; if (huff_done !== 1'b0) begin n_bad++; $display("FAIL hold_done_drop got %b exp 0", huff_done); end
    do_run(cyc);
    d = first_diff();
    n_cmp++; if (d != -1 || huff_done !== 1'b1) begin n_bad++; $display("FAIL hold_rerun_image first bad entry %0d done %b", d, huff_done); end
    huff_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_build();
    int cyc, d, guard, rb;
    for (int i = 0; i < NSYM; i++) hist[i] = 8'(16 - i);
    wbase = wlog.size();
    rbase = rlog.size();
    @(negedge clk);
    huff_start = 1'b1;
    guard = 0;
    while ((rlog.size() - rbase < 2 * NSYM || read) && guard < 100) begin @(negedge clk); guard++; end
    n_cmp++; if (guard >= 100) begin n_bad++; $display("FAIL midrst_load_end got timeout exp load finished"); end
    repeat (3) @(negedge clk);
    huff_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({huff_done, read, write} !== 3'b000 || addr !== 16'h0 || data !== 8'h0) begin
      n_bad++; $display("FAIL midrst_async got done/rd/wr=%b%b%b addr=%h data=%h exp zeros", huff_done, read, write, addr, data); end
    n_cmp++; if (wlog.size() != wbase) begin n_bad++; $display("FAIL midrst_no_writes got %0d exp 0", wlog.size() - wbase); end
    @(negedge clk);
    rst = 1'b0;
    rb = rlog.size();
    repeat (5) @(negedge clk);
    n_cmp++; if (rlog.size() != rb) begin n_bad++; $display("FAIL midrst_idle got %0d reads exp 0", rlog.size() - rb); end
    for (int i = 0; i < NSYM; i++) hist[i] = 8'($urandom_range(0, 255));
    model();
    do_run(cyc);
    d = first_diff();
    n_cmp++; if (d != -1 || huff_done !== 1'b1) begin n_bad++; $display("FAIL midrst_rerun first bad entry %0d done %b", d, huff_done); end
    huff_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, d;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NSYM; i++)
        hist[i] = ($urandom_range(0, 2) == 0) ? 8'h00
                : (it[0] ? 8'($urandom_range(1, 3)) : 8'($urandom_range(1, 255)));
      model();
      do_run(cyc);
      d = first_diff();
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rand%0d_image first bad entry %0d got %0d writes exp %0d", it, d, wlog.size() - wbase, exp_w.size()); end
      n_cmp++; if (huff_done !== 1'b1 || cyc > lat_bound(exp_cnt)) begin
        n_bad++; $display("FAIL rand%0d_latency got %0d (done %b) exp <= %0d", it, cyc, huff_done, lat_bound(exp_cnt)); end
      n_cmp++; if (bad_reads() != 0) begin n_bad++; $display("FAIL rand%0d_reads got %0d bad exp 0", it, bad_reads()); end
      huff_start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_descending();
    test_all_zero();
    test_ties();
    test_single();
    test_hold_start();
    test_reset_mid_build();
    test_random();
    n_cmp++; if (rw_clash != 0) begin n_bad++; $display("FAIL rw_exclusive got %0d overlapping cycles exp 0", rw_clash); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
